// File: rtl/instr_encoder.sv
// Program loader: encodes op requests into RV32I words and streams them into
// instruction memory at consecutive word addresses until the memory is full.
//
// state   | meaning
// --------+-------------------------------------------
// EMPTY   | no words accepted since reset/clear
// LOADING | at least one word accepted, room remains
// FULL    | DEPTH words accepted, requests stalled
module instr_encoder #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [12:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              err,
    output logic [2:0]        err_op
);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_LOADING = 2'd1,
        ST_FULL    = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_LW  = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_BEQ = 3'd6;

    state_t      state;
    state_t      state_next;
    logic [31:0] enc_word;
    logic        enc_legal;
    logic        accept;
    logic        do_write;
    logic        do_reject;

    // Encoder: legality and machine word are derived purely from the request.
    always_comb begin
        enc_word  = 32'h0;
        enc_legal = 1'b1;
        case (in_op)
            OP_ADD: enc_word = {7'h00, in_rs2, in_rs1, 3'b000, in_rd, 7'h33};
            OP_SUB: enc_word = {7'h20, in_rs2, in_rs1, 3'b000, in_rd, 7'h33};
            OP_AND: enc_word = {7'h00, in_rs2, in_rs1, 3'b111, in_rd, 7'h33};
            OP_OR:  enc_word = {7'h00, in_rs2, in_rs1, 3'b110, in_rd, 7'h33};
            OP_LW: begin
                enc_legal = (in_imm[12] == in_imm[11]);
                enc_word  = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'h03};
            end
            OP_SW: begin
                enc_legal = (in_imm[12] == in_imm[11]);
                enc_word  = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'h23};
            end
            OP_BEQ: begin
                enc_legal = ~in_imm[0];
                enc_word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                             in_imm[4:1], in_imm[11], 7'h63};
            end
            default: enc_legal = 1'b0;
        endcase
    end

    assign accept    = in_valid && in_ready;
    assign do_write  = accept && enc_legal;
    assign do_reject = accept && !enc_legal;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = ST_EMPTY;
        end else if (do_write) begin
            state_next = (count == LAST_IDX) ? ST_FULL : ST_LOADING;
        end
    end

    always_comb begin
        in_ready = (state != ST_FULL) && !clear;
        full     = (state == ST_FULL);
    end

    // A write registered before clear still goes out; reset drops it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'h0;
            count      <= '0;
            err        <= 1'b0;
            err_op     <= 3'd0;
        end else begin
            imem_we <= do_write;
            if (do_write) begin
                imem_addr  <= ADDR_W'(count) << 2;
                imem_wdata <= enc_word;
            end
            if (clear) begin
                count  <= '0;
                err    <= 1'b0;
                err_op <= 3'd0;
            end else begin
                if (do_write) begin
                    count <= count + CNT_W'(1);
                end
                if (do_reject && !err) begin
                    err    <= 1'b1;
                    err_op <= in_op;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed program fragments plus a
// randomized stream checked against an arithmetic reference model.
module tb_instr_encoder;

    localparam int DEPTH  = 64;
    localparam int ADDR_W = 8;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clear = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [2:0]        in_op = 3'd0;
    logic [4:0]        in_rd = 5'd0;
    logic [4:0]        in_rs1 = 5'd0;
    logic [4:0]        in_rs2 = 5'd0;
    logic [12:0]       in_imm = 13'd0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              err;
    logic [2:0]        err_op;

    instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .count(count), .full(full), .err(err), .err_op(err_op)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    int          m_count = 0;
    logic        m_err = 1'b0;
    logic [2:0]  m_err_op = 3'd0;
    logic        e_we = 1'b0;
    logic [31:0] e_addr = 32'd0;
    logic [31:0] e_wdata = 32'd0;
    logic        e_ready;
    logic        obs_ready;

    function automatic logic [31:0] ref_enc(input int op, input int rd, input int rs1,
                                            input int rs2, input int imm);
        logic [31:0] w;
        int f3, f7;
        w = 0;
        if (op <= 3) begin
            f7 = (op == 1) ? 32 : 0;
            f3 = (op == 2) ? 7 : (op == 3) ? 6 : 0;
            w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 51;
        end else if (op == 4) begin
            w = ((imm & 4095) << 20) | (rs1 << 15) | (2 << 12) | (rd << 7) | 3;
        end else if (op == 5) begin
            w = (((imm >>> 5) & 127) << 25) | (rs2 << 20) | (rs1 << 15) | (2 << 12)
                | ((imm & 31) << 7) | 35;
        end else if (op == 6) begin
            w = (((imm >>> 12) & 1) << 31) | (((imm >>> 5) & 63) << 25) | (rs2 << 20)
                | (rs1 << 15) | (((imm >>> 1) & 15) << 8) | (((imm >>> 11) & 1) << 7) | 99;
        end
        return w;
    endfunction

    function automatic bit ref_legal(input int op, input int imm);
        if (op == 7) return 1'b0;
        if (op == 4 || op == 5) return (imm >= -2048) && (imm <= 2047);
        if (op == 6) return (imm % 2) == 0;
        return 1'b1;
    endfunction

    // Drive one cycle at posedge+1, advance the model, return at next posedge+1.
    task automatic cycle(input logic v, input logic [2:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [12:0] imm, input logic clr, input logic rst);
        int imm_s;
        in_valid = v; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        clear = clr; rst_n = !rst;
        #1;
        obs_ready = in_ready;
        e_ready = (m_count != DEPTH) && !clr;
        imm_s = int'($signed(imm));
        if (rst) begin
            e_we = 0; e_addr = 0; e_wdata = 0; m_count = 0; m_err = 0; m_err_op = 0;
        end else if (clr) begin
            e_we = 0; m_count = 0; m_err = 0; m_err_op = 0;
        end else if (v && m_count < DEPTH) begin
            if (ref_legal(int'(op), imm_s)) begin
                e_we = 1;
                e_addr = m_count * 4;
                e_wdata = ref_enc(int'(op), int'(rd), int'(rs1), int'(rs2), imm_s);
                m_count++;
            end else begin
                e_we = 0;
                if (!m_err) begin m_err = 1; m_err_op = op; end
            end
        end else begin
            e_we = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cycle(0, 3'd0, 5'd0, 5'd0, 5'd0, 13'd0, 0, 0);
    endtask

    task automatic test_reset();
        cycle(0, 3'd0, 5'd0, 5'd0, 5'd0, 13'd0, 0, 1);
        cycle(0, 3'd0, 5'd0, 5'd0, 5'd0, 13'd0, 0, 1);
        n_chk++; if (imem_we !== 1'b0) begin n_err++; $display("FAIL reset_we got=%b want=0", imem_we); end
        n_chk++; if (imem_addr !== 8'h00) begin n_err++; $display("FAIL reset_addr got=%h want=00", imem_addr); end
        n_chk++; if (imem_wdata !== 32'h0) begin n_err++; $display("FAIL reset_wdata got=%h want=0", imem_wdata); end
        n_chk++; if (count !== 7'd0 || full !== 1'b0) begin n_err++; $display("FAIL reset_count got=%0d/%b want=0/0", count, full); end
        n_chk++; if (err !== 1'b0 || err_op !== 3'd0) begin n_err++; $display("FAIL reset_err got=%b/%0d want=0/0", err, err_op); end
        idle();
        n_chk++; if (obs_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b want=1", obs_ready); end
    endtask

    task automatic test_add();
        cycle(1, 3'd0, 5'd3, 5'd1, 5'd2, 13'd0, 0, 0);
        n_chk++; if (imem_we !== 1'b1 || imem_addr !== 8'h00 || imem_wdata !== 32'h002081B3)
            begin n_err++; $display("FAIL add_write got=%b/%h/%h want=1/00/002081b3", imem_we, imem_addr, imem_wdata); end
        n_chk++; if (count !== 7'd1) begin n_err++; $display("FAIL add_count got=%0d want=1", count); end
        idle();
        n_chk++; if (imem_we !== 1'b0) begin n_err++; $display("FAIL add_idle_we got=%b want=0", imem_we); end
    endtask

    task automatic test_back_to_back();
        cycle(0, 3'd0, 5'd0, 5'd0, 5'd0, 13'd0, 0, 1);
        cycle(1, 3'd1, 5'd5, 5'd6, 5'd7, 13'd0, 0, 0);
        n_chk++; if (imem_we !== 1'b1 || imem_addr !== 8'h00 || imem_wdata !== 32'h407302B3)
            begin n_err++; $display("FAIL b2b_sub got=%b/%h/%h want=1/00/407302b3", imem_we, imem_addr, imem_wdata); end
        cycle(1, 3'd4, 5'd4, 5'd2, 5'd0, 13'd8, 0, 0);
        n_chk++; if (imem_we !== 1'b1 || imem_addr !== 8'h04 || imem_wdata !== 32'h00812203)
            begin n_err++; $display("FAIL b2b_lw got=%b/%h/%h want=1/04/00812203", imem_we, imem_addr, imem_wdata); end
        cycle(1, 3'd5, 5'd0, 5'd2, 5'd5, 13'd12, 0, 0);
        n_chk++; if (imem_we !== 1'b1 || imem_addr !== 8'h08 || imem_wdata !== 32'h00512623)
            begin n_err++; $display("FAIL b2b_sw got=%b/%h/%h want=1/08/00512623", imem_we, imem_addr, imem_wdata); end
        n_chk++; if (count !== 7'd3) begin n_err++; $display("FAIL b2b_count got=%0d want=3", count); end
    endtask

    task automatic test_beq();
        cycle(1, 3'd6, 5'd0, 5'd1, 5'd2, 13'h1FF8, 0, 0);
        n_chk++; if (imem_we !== 1'b1 || imem_addr !== 8'h0C || imem_wdata !== 32'hFE208CE3)
            begin n_err++; $display("FAIL beq_write got=%b/%h/%h want=1/0c/fe208ce3", imem_we, imem_addr, imem_wdata); end
        cycle(1, 3'd6, 5'd0, 5'd1, 5'd2, 13'd5, 0, 0);
        n_chk++; if (imem_we !== 1'b0 || err !== 1'b1 || err_op !== 3'd6 || count !== 7'd4)
            begin n_err++; $display("FAIL beq_odd got=we%b err%b op%0d cnt%0d want=we0 err1 op6 cnt4", imem_we, err, err_op, count); end
    endtask

    task automatic test_illegal();
        cycle(0, 3'd0, 5'd0, 5'd0, 5'd0, 13'd0, 1, 0);
        n_chk++; if (count !== 7'd0 || err !== 1'b0 || err_op !== 3'd0)
            begin n_err++; $display("FAIL clear_state got=cnt%0d err%b op%0d want=0/0/0", count, err, err_op); end
        cycle(1, 3'd7, 5'd1, 5'd1, 5'd1, 13'd0, 0, 0);
        n_chk++; if (imem_we !== 1'b0 || err !== 1'b1 || err_op !== 3'd7)
            begin n_err++; $display("FAIL illegal_op got=we%b err%b op%0d want=we0 err1 op7", imem_we, err, err_op); end
        cycle(1, 3'd2, 5'd1, 5'd2, 5'd3, 13'd0, 0, 0);
        n_chk++; if (imem_we !== 1'b1 || imem_addr !== 8'h00 || imem_wdata !== 32'h003170B3 || err_op !== 3'd7)
            begin n_err++; $display("FAIL illegal_then_and got=%b/%h/%h op%0d want=1/00/003170b3 op7", imem_we, imem_addr, imem_wdata, err_op); end
        cycle(1, 3'd4, 5'd1, 5'd2, 5'd3, 13'h0800, 0, 0);
        n_chk++; if (imem_we !== 1'b0 || err_op !== 3'd7 || count !== 7'd1)
            begin n_err++; $display("FAIL lw_range got=we%b op%0d cnt%0d want=we0 op7 cnt1", imem_we, err_op, count); end
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        cycle(0, 3'd0, 5'd0, 5'd0, 5'd0, 13'd0, 0, 1);
        for (int i = 0; i < 300; i++) begin
            logic [12:0] imm;
            imm = ($urandom_range(0, 3) == 0) ? 13'($urandom_range(2040, 2056)) : 13'($urandom);
            if ($urandom_range(0, 7) == 0) imm = -imm;
            cycle($urandom_range(0, 4) != 0, 3'($urandom_range(0, 7)), 5'($urandom),
                  5'($urandom), 5'($urandom), imm, $urandom_range(0, 39) == 0, 0);
            n_chk++;
            if (imem_we !== e_we || (e_we && (imem_addr !== e_addr[7:0] || imem_wdata !== e_wdata))
                || count !== CNT_W'(m_count) || err !== m_err || err_op !== m_err_op
                || full !== (m_count == DEPTH) || obs_ready !== e_ready) begin
                n_err++;
                if (bad < 10)
                    $display("FAIL rand_%0d got=we%b a%h d%h c%0d e%b o%0d r%b want=we%b a%h d%h c%0d e%b o%0d r%b",
                             i, imem_we, imem_addr, imem_wdata, count, err, err_op, obs_ready,
                             e_we, e_addr[7:0], e_wdata, m_count, m_err, m_err_op, e_ready);
                bad++;
            end
        end
    endtask

    task automatic test_fill();
        int writes;
        writes = 0;
        cycle(0, 3'd0, 5'd0, 5'd0, 5'd0, 13'd0, 1, 0);
        for (int i = 0; i < DEPTH + 5; i++) begin
            cycle(1, 3'd0, 5'd1, 5'd2, 5'd3, 13'd0, 0, 0);
            if (imem_we === 1'b1) begin
                writes++;
                if (writes == DEPTH) begin
                    n_chk++; if (imem_addr !== 8'(4 * (DEPTH - 1)))
                        begin n_err++; $display("FAIL fill_last_addr got=%h want=%h", imem_addr, 8'(4 * (DEPTH - 1))); end
                end
            end
        end
        n_chk++; if (writes != DEPTH) begin n_err++; $display("FAIL fill_writes got=%0d want=%0d", writes, DEPTH); end
        n_chk++; if (full !== 1'b1 || count !== 7'(DEPTH) || obs_ready !== 1'b0)
            begin n_err++; $display("FAIL fill_full got=full%b cnt%0d rdy%b want=1/%0d/0", full, count, obs_ready, DEPTH); end
        cycle(1, 3'd0, 5'd1, 5'd2, 5'd3, 13'd0, 1, 0);
        n_chk++; if (count !== 7'd0 || full !== 1'b0)
            begin n_err++; $display("FAIL fill_clear got=cnt%0d full%b want=0/0", count, full); end
        cycle(1, 3'd3, 5'd1, 5'd2, 5'd3, 13'd0, 0, 0);
        n_chk++; if (imem_we !== 1'b1 || imem_addr !== 8'h00 || imem_wdata !== 32'h003160B3)
            begin n_err++; $display("FAIL fill_restart got=%b/%h/%h want=1/00/003160b3", imem_we, imem_addr, imem_wdata); end
    endtask

    task automatic test_clear_after_accept();
        cycle(1, 3'd0, 5'd3, 5'd1, 5'd2, 13'd0, 0, 0);
        n_chk++; if (imem_we !== 1'b1 || imem_addr !== 8'h04 || imem_wdata !== 32'h002081B3)
            begin n_err++; $display("FAIL clr_pending got=%b/%h/%h want=1/04/002081b3", imem_we, imem_addr, imem_wdata); end
        cycle(1, 3'd0, 5'd3, 5'd1, 5'd2, 13'd0, 1, 0);
        n_chk++; if (obs_ready !== 1'b0) begin n_err++; $display("FAIL clr_ready got=%b want=0", obs_ready); end
        n_chk++; if (count !== 7'd0 || imem_we !== 1'b0)
            begin n_err++; $display("FAIL clr_after got=cnt%0d we%b want=0/0", count, imem_we); end
    endtask

    task automatic test_reset_after_accept();
        cycle(1, 3'd7, 5'd0, 5'd0, 5'd0, 13'd0, 0, 0);
        cycle(1, 3'd1, 5'd5, 5'd6, 5'd7, 13'd0, 0, 0);
        cycle(1, 3'd1, 5'd5, 5'd6, 5'd7, 13'd0, 0, 1);
        n_chk++; if (imem_we !== 1'b0 || imem_addr !== 8'h00 || imem_wdata !== 32'h0)
            begin n_err++; $display("FAIL rst_drop got=%b/%h/%h want=0/00/0", imem_we, imem_addr, imem_wdata); end
        n_chk++; if (count !== 7'd0 || full !== 1'b0 || err !== 1'b0 || err_op !== 3'd0)
            begin n_err++; $display("FAIL rst_state got=c%0d f%b e%b o%0d want=0/0/0/0", count, full, err, err_op); end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_add();
        test_back_to_back();
        test_beq();
        test_illegal();
        test_random();
        test_fill();
        test_clear_after_accept();
        test_reset_after_accept();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Program loader that encodes decoded operation requests (op, rd, rs1, rs2, imm) into 32-bit RV32I machine words and writes them sequentially into instruction memory. It produces the instruction stream that the single-cycle control decoder consumes. Supported formats are R (add/sub/and/or), I-load (lw), S (sw) and B (beq). It is used by self-test and bring-up logic to build programs in hardware.

Parameters:
DEPTH, 64, instruction memory capacity in 32-bit words.
ADDR_W, 8, imem byte-address width; DEPTH*4 <= 2**ADDR_W required.
CNT_W, $clog2(DEPTH)+1, width of the word counter.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
clear  input  1  synchronous restart: pointer, count and err to 0
in_valid  input  1  request valid
in_ready  output  1  request accepted when in_valid && in_ready
in_op  input  3  0=ADD 1=SUB 2=AND 3=OR 4=LW 5=SW 6=BEQ 7=illegal
in_rd  input  5  destination register (R, LW)
in_rs1  input  5  source 1 (R, LW, SW, BEQ)
in_rs2  input  5  source 2 (R, SW, BEQ)
in_imm  input  13  signed immediate; LW/SW use [11:0], BEQ uses [12:0]
imem_we  output  1  instruction memory write strobe
imem_addr  output  ADDR_W  byte address, word aligned
imem_wdata  output  32  encoded instruction
count  output  CNT_W  number of words accepted since reset/clear
full  output  1  count == DEPTH
err  output  1  sticky: a rejected request occurred
err_op  output  3  in_op of the first rejected request

Behaviour:
- Reset (rst_n=0 at a clk edge): imem_we=0, imem_addr=0, imem_wdata=0, count=0, full=0, err=0, err_op=0. State=EMPTY.
- States: EMPTY (count=0), LOADING (0<count<DEPTH), FULL (count=DEPTH).
  - EMPTY->LOADING on a valid write.
  - LOADING->FULL when count reaches DEPTH.
  - Any state->EMPTY on clear.
- in_ready = !full && !clear (combinational).
- Accept in cycle N: the word is encoded and registered, so imem_we=1 in cycle N+1 with imem_addr=count_N*4 and the encoded data. count increments at the same edge.
- Back-to-back accepts give one write per cycle with no bubbles. imem_we=0 in any cycle not following a valid accept.
- Encodings:
  - R-type: {f7, rs2, rs1, f3, rd, 7'h33}. ADD f3=000 f7=00. SUB f3=000 f7=20h. AND f3=111 f7=00. OR f3=110 f7=00.
  - LW: {imm[11:0], rs1, 010, rd, 7'h03}.
  - SW: {imm[11:5], rs2, rs1, 010, imm[4:0], 7'h23}.
  - BEQ: {imm[12], imm[10:5], rs2, rs1, 000, imm[4:1], imm[11], 7'h63}.
- Unused fields are ignored (e.g. rd for SW/BEQ, imm for R-type).
- Reject rules (request is consumed, no write, count unchanged):
  - in_op=7.
  - LW/SW with imm[12] != imm[11] (out of 12-bit signed range).
  - BEQ with imm[0]=1.
  - On the first reject, err is set and err_op is captured. Later rejects leave err_op unchanged.
- full: a request held while full is not accepted (in_ready=0). It must be held stable until clear.
- clear in cycle N:
  - in_ready=0 in cycle N.
  - At the next edge: count=0, err=0, err_op=0.
  - A write already registered from an accept in cycle N-1 is still issued in cycle N.
- rst_n has priority over clear. clear has priority over accept.
- Reset mid-stream discards any pending registered write: imem_we=0 in the cycle after reset.
- Address wrap is impossible because acceptance stops at DEPTH.

Test Plan:
- Reset, then ADD rd=3 rs1=1 rs2=2 -> next cycle imem_we=1, addr=0x00, wdata=0x002081B3, count=1.
- Back-to-back: SUB rd=5 rs1=6 rs2=7; LW rd=4 rs1=2 imm=8; SW rs2=5 rs1=2 imm=12 -> consecutive writes at 0x00/0x04/0x08 with wdata 0x407302B3 / 0x00812203 / 0x00512623, count=3.
- BEQ rs1=1 rs2=2 imm=13'h1FF8 (-8) -> wdata=0xFE208CE3. BEQ imm=5 -> no write, err=1, err_op=6, count unchanged.
- Illegal op 7, then a valid AND rd=1 rs1=2 rs2=3 -> err_op stays 7; AND writes 0x003170B3 at the next address.
- Fill DEPTH words with in_valid held high -> full=1 and in_ready=0 after the DEPTH-th accept, exactly DEPTH writes seen. clear -> count=0, full=0, next write at addr 0.
- Accept in cycle N with clear and rst_n high in N+1 -> write still issued in N+1, count=0 afterwards. Repeat with rst_n=0 in N+1 -> no write, all outputs at reset values.
